triangle_controller: RTL

TRIANGLE_CONTROLLER -- requirements
Module: triangle_controller

---
 rtl/triangle_controller_if.sv | 53 +++++
 rtl/triangle_controller.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/triangle_controller_if.sv
// Controller <-> shader / rasterizer signal bundle.
// The controller uses the slave modport; the environment driving it uses master.
interface triangle_controller_if #(
    parameter int unsigned FIFO_DEPTH = 4
) ();
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              enable;
    logic [19:0]       num_vertices;
    logic              start_doing_shading;
    logic              MVP_ready;
    logic              controller_signal_get;
    logic [19:0]       controller_which_vertice;
    logic              data_ready;
    logic [20:0]       vertice1_depth_update;
    logic [20:0]       vertice2_depth_update;
    logic [20:0]       vertice3_depth_update;
    logic [23:0]       vertice1_color_update;
    logic [23:0]       vertice2_color_update;
    logic [23:0]       vertice3_color_update;
    logic [11:0]       screen_x1_update;
    logic [11:0]       screen_x2_update;
    logic [11:0]       screen_x3_update;
    logic [11:0]       screen_y1_update;
    logic [11:0]       screen_y2_update;
    logic [11:0]       screen_y3_update;
    logic              tri_valid;
    logic              tri_ready;
    logic [206:0]      tri_data;
    logic [CNT_W-1:0]  fifo_count;
    logic              busy;
    logic              done;

    modport slave (
        input  enable, num_vertices, MVP_ready, data_ready, tri_ready,
        input  vertice1_depth_update, vertice2_depth_update, vertice3_depth_update,
        input  vertice1_color_update, vertice2_color_update, vertice3_color_update,
        input  screen_x1_update, screen_x2_update, screen_x3_update,
        input  screen_y1_update, screen_y2_update, screen_y3_update,
        output start_doing_shading, controller_signal_get, controller_which_vertice,
        output tri_valid, tri_data, fifo_count, busy, done
    );

    modport master (
        output enable, num_vertices, MVP_ready, data_ready, tri_ready,
        output vertice1_depth_update, vertice2_depth_update, vertice3_depth_update,
        output vertice1_color_update, vertice2_color_update, vertice3_color_update,
        output screen_x1_update, screen_x2_update, screen_x3_update,
        output screen_y1_update, screen_y2_update, screen_y3_update,
        input  start_doing_shading, controller_signal_get, controller_which_vertice,
        input  tri_valid, tri_data, fifo_count, busy, done
    );
endinterface

// File: rtl/triangle_controller.sv
// Walks a frame's vertex list one triangle at a time through the vertex shader
// and buffers the shaded triangles in a small FIFO for the rasterizer.
module triangle_controller #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    triangle_controller_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned IDX_W = 20;
    localparam int unsigned TRI_W = 207;

    typedef enum logic [2:0] {
        IDLE, WAIT_MVP, ISSUE, WAIT_DATA, DRAIN, DONE
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] nv_q, nv_d;
    logic [IDX_W-1:0] base_q, base_d;
    logic [IDX_W-1:0] which_q, which_d;
    logic             get_q, get_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tri_valid_q, tri_valid_d;
    logic [TRI_W-1:0] tri_data_q, tri_data_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TRI_W-1:0] mem_q [FIFO_DEPTH];

    logic             push;
    logic             pop;
    logic             slot_free;
    logic             last_tri;
    logic [TRI_W-1:0] push_data;

    // Vertex 1 in the MSBs, each vertex packed as {x, y, depth, color}.
    assign push_data = {bus.screen_x1_update, bus.screen_y1_update,
                        bus.vertice1_depth_update, bus.vertice1_color_update,
                        bus.screen_x2_update, bus.screen_y2_update,
                        bus.vertice2_depth_update, bus.vertice2_color_update,
                        bus.screen_x3_update, bus.screen_y3_update,
                        bus.vertice3_depth_update, bus.vertice3_color_update};

    always_comb begin
        state_d   = state_q;
        nv_d      = nv_q;
        base_d    = base_q;
        which_d   = which_q;
        get_d     = 1'b0;
        start_d   = 1'b0;
        push      = 1'b0;
        pop       = tri_valid_q & bus.tri_ready;
        slot_free = (count_q < CNT_W'(FIFO_DEPTH)) | pop;
        // Widened compare: no further full triangle fits after the current one.
        last_tri  = ({1'b0, base_q} + 21'd6) > {1'b0, nv_q};

        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    nv_d    = bus.num_vertices;
                    base_d  = '0;
                    start_d = 1'b1;
                    state_d = WAIT_MVP;
                end
            end
            WAIT_MVP: begin
                if (bus.MVP_ready) begin
                    state_d = (nv_q < 20'd3) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                // Only request once a FIFO slot is guaranteed for the reply.
                if (slot_free) begin
                    get_d   = 1'b1;
                    which_d = base_q;
                    state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (bus.data_ready) begin
                    push    = 1'b1;
                    base_d  = base_q + 20'd3;
                    state_d = last_tri ? DRAIN : ISSUE;
                end
            end
            DRAIN: begin
                if (count_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        // Head register: bypass the incoming entry when it becomes the head.
        tri_valid_d = (count_d != '0);
        tri_data_d  = tri_data_q;
        if (count_d != '0) begin
            tri_data_d = (push && (wr_ptr_q == rd_ptr_d)) ? push_data : mem_q[rd_ptr_d];
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            nv_q        <= '0;
            base_q      <= '0;
            which_q     <= '0;
            get_q       <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tri_valid_q <= 1'b0;
            tri_data_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            nv_q        <= nv_d;
            base_q      <= base_d;
            which_q     <= which_d;
            get_q       <= get_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tri_valid_q <= tri_valid_d;
            tri_data_q  <= tri_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
            end
        end
    end

    assign bus.start_doing_shading      = start_q;
    assign bus.controller_signal_get    = get_q;
    assign bus.controller_which_vertice = which_q;
    assign bus.tri_valid                = tri_valid_q;
    assign bus.tri_data                 = tri_data_q;
    assign bus.fifo_count               = count_q;
    assign bus.busy                     = busy_q;
    assign bus.done                     = done_q;
endmodule
